// File: rtl/r_rom_byte_link.sv
// Byte link between the R-ROM TileLink frontend and the FT232H FIFOs: serialises one read command
// frame, collects the little-endian response bytes and returns one word, with a dead-link timeout.

module r_rom_byte_lane #(
  parameter int LANE = 0,
  parameter int CW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cap,
  input  logic [CW-1:0] recv,
  input  logic [7:0]    dout,
  output logic [7:0]    q
);
  always_ff @(posedge clk) begin
    if (rst || clr)                    q <= '0;
    else if (cap && recv == CW'(LANE)) q <= dout;
  end
endmodule

module r_rom_byte_link #(
  parameter int         ADDR_BYTES = 8,
  parameter int         DATA_BYTES = 8,
  parameter logic [7:0] CMD_READ   = 8'h01,
  parameter int         TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [8*ADDR_BYTES-1:0] req_addr,
  input  logic                    full,
  output logic                    wr_en,
  output logic [7:0]              din,
  input  logic                    empty,
  output logic                    rd_en,
  input  logic [7:0]              dout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_data,
  output logic                    rsp_err
);
  localparam int FW = 8 * (ADDR_BYTES + 1);
  localparam int IW = $clog2(ADDR_BYTES + 2);
  localparam int CW = $clog2(DATA_BYTES + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(ADDR_BYTES);
  localparam logic [CW-1:0] NBYTES    = CW'(DATA_BYTES);
  localparam logic [CW-1:0] LAST_RECV = CW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] T_LAST    = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, RESP} state_t;
  state_t state, state_nxt;

  logic [FW-1:0] frame;
  logic [IW-1:0] idx;
  logic [CW-1:0] issued, recv;
  logic [TW-1:0] tcnt;
  logic          pend, cap, last_cap, tmo, rd_recv, accept;
  logic [DATA_BYTES-1:0][7:0] data_q;

  // pend marks a RECV read whose byte shows up on dout this cycle
  assign cap      = (state == RECV) && pend;
  assign last_cap = cap && (recv == LAST_RECV);
  assign tmo      = (state == RECV) && (tcnt == T_LAST);
  assign accept   = (state == IDLE) && req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)                     state_nxt = SEND;
      SEND:    if (wr_en && idx == LAST_IDX)   state_nxt = RECV;
      RECV:    if (last_cap || tmo)            state_nxt = RESP;
      RESP:    if (rsp_ready)                  state_nxt = IDLE;
      default:                                 state_nxt = IDLE;
    endcase
  end

  // outputs are forced quiet while rst is high so an abort is visible at once
  always_comb begin
    req_ready = 1'b0;
    wr_en     = 1'b0;
    din       = 8'h00;
    rd_en     = 1'b0;
    rd_recv   = 1'b0;
    rsp_valid = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          req_ready = empty;
          rd_en     = !empty;
        end
        SEND: begin
          wr_en = !full;
          din   = full ? 8'h00 : frame[7:0];
        end
        RECV: begin
          // no new read in the timeout cycle: its byte would land after we left RECV
          rd_recv = !empty && (issued < NBYTES) && !tmo;
          rd_en   = rd_recv;
        end
        RESP:    rsp_valid = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame   <= '0;
      idx     <= '0;
      issued  <= '0;
      recv    <= '0;
      tcnt    <= '0;
      pend    <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      pend <= rd_recv;
      case (state)
        IDLE: if (accept) begin
          frame   <= {req_addr, CMD_READ};
          idx     <= '0;
          issued  <= '0;
          recv    <= '0;
          rsp_err <= 1'b0;
        end
        SEND: begin
          tcnt <= '0;
          if (wr_en) begin
            frame <= frame >> 8;
            idx   <= idx + 1'b1;
          end
        end
        RECV: begin
          if (rd_recv) issued <= issued + 1'b1;
          if (cap) begin
            recv <= recv + 1'b1;
            tcnt <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
          if (state_nxt == RESP) rsp_err <= !last_cap;
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < DATA_BYTES; k++) begin : g_lane
    r_rom_byte_lane #(.LANE(k), .CW(CW)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .cap  (cap),
      .recv (recv),
      .dout (dout),
      .q    (data_q[k])
    );
  end

  assign rsp_data = data_q;
endmodule

// File: tb/tb_r_rom_byte_link.sv
// Scoreboard bench for r_rom_byte_link: command bytes and responses are queued when issued and
// checked by negedge monitors; the response FIFO is a queue with a registered read port.

module tb_r_rom_byte_link;
  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, wr_en, rd_en, rsp_valid, rsp_ready, rsp_err;
  logic        full = 1'b0;
  logic        empty = 1'b1;
  logic [63:0] req_addr, rsp_data;
  logic [7:0]  din;
  logic [7:0]  dout = 8'h00;

  always #5 clk = ~clk;

  r_rom_byte_link #(.ADDR_BYTES(8), .DATA_BYTES(8), .CMD_READ(8'h01), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .full(full), .wr_en(wr_en), .din(din), .empty(empty), .rd_en(rd_en), .dout(dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  int checks = 0, errs = 0, cyc = 0;
  int rd_cnt = 0, wr_cnt = 0, last_rd_cyc = 0, last_wr_cyc = 0, acc_cyc = 0;
  logic [7:0]  rq[$];
  logic [7:0]  exp_cmd[$];
  logic [64:0] exp_rsp[$];
  logic        tog = 1'b0;

  task automatic chk(input string n, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic flag(input string n);
    checks++;
    errs++;
    $display("FAIL %s: bound expired or unexpected event", n);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // response FIFO model: registered dout, empty refreshed after stimulus pushes
  always @(posedge clk) begin
    if (rd_en && rq.size() > 0) dout <= rq.pop_front();
    #2 empty <= (rq.size() == 0);
  end

  always @(posedge clk) begin
    #1 full <= tog ? ~full : 1'b0;
  end

  always @(negedge clk) begin
    if (rd_en) begin
      rd_cnt      <= rd_cnt + 1;
      last_rd_cyc <= cyc;
    end
    if (wr_en) begin
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
      chk("wr_while_full", {64'd0, full}, 65'd0);
      if (exp_cmd.size() == 0) flag("unexpected_write");
      else                     chk("cmd_byte", {57'd0, din}, {57'd0, exp_cmd.pop_front()});
    end
    if (rsp_valid && rsp_ready) begin
      if (exp_rsp.size() == 0) flag("unexpected_rsp");
      else                     chk("rsp_err_data", {rsp_err, rsp_data}, exp_rsp.pop_front());
    end
    if (!rst && !empty) chk("req_ready_nonempty", {64'd0, req_ready}, 65'd0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] a);
    bit ok;
    ok = 1'b0;
    exp_cmd.push_back(8'h01);
    for (int i = 0; i < 8; i++) exp_cmd.push_back(a[8*i +: 8]);
    req_addr  = a;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
      end
    end
    step();
    req_valid = 1'b0;
    if (!ok) flag("accept");
  endtask

  task automatic wait_cmd();
    for (int i = 0; i < 200 && exp_cmd.size() != 0; i++) step();
    if (exp_cmd.size() != 0) flag("cmd_done");
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 200 && exp_rsp.size() != 0; i++) step();
    if (exp_rsp.size() != 0) flag("rsp_done");
  endtask

  task automatic feed(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) rq.push_back(w[8*i +: 8]);
  endtask

  task automatic chk_quiet(input string n);
    chk({n, "_wr_en"}, {64'd0, wr_en}, 65'd0);
    chk({n, "_rd_en"}, {64'd0, rd_en}, 65'd0);
    chk({n, "_rsp_valid"}, {64'd0, rsp_valid}, 65'd0);
    chk({n, "_rsp_err"}, {64'd0, rsp_err}, 65'd0);
    chk({n, "_rsp_data"}, {1'b0, rsp_data}, 65'd0);
    chk({n, "_din"}, {57'd0, din}, 65'd0);
  endtask

  initial begin
    int w0, r0;
    bit seen;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    repeat (3) step();
    req_valid = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {64'd0, req_ready}, 65'd0);
    chk_quiet("rst");
    step();
    req_valid = 1'b0;
    rst = 1'b0;
    step();

    // 1: plain read
    issue(64'h0000_0000_8000_0010);
    wait_cmd();
    chk("send_latency", 65'(last_wr_cyc - acc_cyc), 65'd9);
    feed(64'h8877665544332211, 8);
    exp_rsp.push_back({1'b0, 64'h8877665544332211});
    wait_rsp();

    // 2: full toggling during SEND
    tog = 1'b1;
    w0 = wr_cnt;
    issue(64'h0000_0000_8000_0010);
    wait_cmd();
    tog = 1'b0;
    repeat (3) step();
    chk("write_count_full", 65'(wr_cnt - w0), 65'd9);
    feed(64'h8877665544332211, 8);
    exp_rsp.push_back({1'b0, 64'h8877665544332211});
    wait_rsp();

    // 3: timeout after three bytes
    issue(64'h0000_0000_0000_0300);
    wait_cmd();
    feed(64'h0000_0000_00CC_BBAA, 3);
    exp_rsp.push_back({1'b1, 64'h0000_0000_00CC_BBAA});
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) flag("timeout_rsp");
    else       chk("timeout_latency", 65'(cyc - last_rd_cyc), 65'd18);
    step();

    // 5: late bytes drained in IDLE
    feed(64'h0000_00F5_F4F3_F2F1, 5);
    r0 = rd_cnt;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (empty && req_ready) seen = 1'b1;
    end
    if (!seen) flag("drain");
    chk("drain_count", 65'(rd_cnt - r0), 65'd5);
    step();

    // 4: consumer backpressure in RESP
    issue(64'h1122_3344_5566_7788);
    wait_cmd();
    rsp_ready = 1'b0;
    feed(64'h0123_4567_89AB_CDEF, 8);
    exp_rsp.push_back({1'b0, 64'h0123_4567_89AB_CDEF});
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    if (!seen) flag("hold_rsp");
    step();
    req_valid = 1'b1;
    req_addr  = 64'hA5A5_0000_0000_5A5A;
    w0 = wr_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_data", {1'b0, rsp_data}, {1'b0, 64'h0123_4567_89AB_CDEF});
      chk("hold_req_ready", {64'd0, req_ready}, 65'd0);
    end
    chk("hold_no_writes", 65'(wr_cnt - w0), 65'd0);
    step();
    rsp_ready = 1'b1;
    issue(64'hA5A5_0000_0000_5A5A);
    wait_cmd();
    feed(64'h0807_0605_0403_0201, 8);
    exp_rsp.push_back({1'b0, 64'h0807_0605_0403_0201});
    wait_rsp();

    // 6: reset in the middle of SEND
    w0 = wr_cnt;
    issue(64'hDEAD_BEEF_CAFE_F00D);
    repeat (4) step();
    chk("pre_rst_writes", 65'(wr_cnt - w0), 65'd4);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req_ready", {64'd0, req_ready}, 65'd0);
    chk("mid_rst_wr_en", {64'd0, wr_en}, 65'd0);
    step();
    rst = 1'b0;
    exp_cmd.delete();
    @(negedge clk);
    chk_quiet("post_rst");
    chk("post_rst_req_ready", {64'd0, req_ready}, 65'd1);
    step();
    issue(64'h0000_0000_8000_0010);
    wait_cmd();
    feed(64'h8877665544332211, 8);
    exp_rsp.push_back({1'b0, 64'h8877665544332211});
    wait_rsp();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
